// File: rtl/sram_bus_ctrl.sv
// Sequences single-cycle requests into CE/OE/WE cycles on an 8-bit async SRAM with bus turnaround.
// Optional write-verify read-back is compiled in by defining SRAM_CTRL_WRVERIFY_EN.
module sram_bus_ctrl #(
    parameter int unsigned AW      = 19,
    parameter int unsigned WAIT_RD = 2,
    parameter int unsigned WAIT_WR = 2,
    parameter int unsigned TURN    = 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          req,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [7:0]    wdata,
    output logic          ready,
    output logic [7:0]    rdata,
    output logic          rvalid,
    output logic          wack,
    output logic          verify_err,
    output logic [AW-1:0] sram_addr,
    output logic          sram_ce_n,
    output logic          sram_oe_n,
    output logic          sram_we_n,
    output logic [7:0]    sram_dout,
    input  logic [7:0]    sram_din,
    output logic          sram_doe
);

    localparam int unsigned MAX_RW   = (WAIT_RD > WAIT_WR) ? WAIT_RD : WAIT_WR;
    localparam int unsigned MAX_WAIT = (MAX_RW > TURN) ? MAX_RW : TURN;
    localparam int unsigned CW       = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

    typedef enum logic [3:0] {
        S_IDLE,
        S_RD_WAIT,
        S_RD_LATCH,
        S_TURN,
        S_WR_SETUP,
        S_WR_PULSE,
        S_WR_HOLD
`ifdef SRAM_CTRL_WRVERIFY_EN
        , S_VFY_WAIT,
        S_VFY_LATCH
`endif
    } state_t;

    // With no turnaround requested, a completed read returns straight to idle.
    localparam state_t AFTER_RD = (TURN == 0) ? S_IDLE : S_TURN;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          accept;
    logic          ready_d, ce_n_d, oe_n_d, we_n_d, doe_d, rvalid_d, wack_d;

    assign accept = req && ready;

    // State, dwell counter and registered strobes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            ready     <= 1'b0;
            sram_ce_n <= 1'b1;
            sram_oe_n <= 1'b1;
            sram_we_n <= 1'b1;
            sram_doe  <= 1'b0;
            rvalid    <= 1'b0;
            wack      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ready     <= ready_d;
            sram_ce_n <= ce_n_d;
            sram_oe_n <= oe_n_d;
            sram_we_n <= we_n_d;
            sram_doe  <= doe_d;
            rvalid    <= rvalid_d;
            wack      <= wack_d;
        end
    end

    // Next state; cnt_q counts cycles already spent in the current state.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        case (state_q)
            S_IDLE:      if (accept) state_d = we ? S_WR_SETUP : S_RD_WAIT;
            S_RD_WAIT:   if (cnt_q == CW'(WAIT_RD - 1)) state_d = S_RD_LATCH;
            S_RD_LATCH:  state_d = AFTER_RD;
            S_TURN:      if (cnt_q == CW'(TURN - 1)) state_d = S_IDLE;
            S_WR_SETUP:  state_d = S_WR_PULSE;
            S_WR_PULSE:  if (cnt_q == CW'(WAIT_WR - 1)) state_d = S_WR_HOLD;
`ifdef SRAM_CTRL_WRVERIFY_EN
            S_WR_HOLD:   state_d = S_VFY_WAIT;
            S_VFY_WAIT:  if (cnt_q == CW'(WAIT_RD - 1)) state_d = S_VFY_LATCH;
            S_VFY_LATCH: state_d = AFTER_RD;
`else
            S_WR_HOLD:   state_d = S_IDLE;
`endif
            default:     state_d = S_IDLE;
        endcase
        if (state_d == state_q && state_q != S_IDLE) cnt_d = cnt_q + CW'(1);
    end

    // Strobe values for the state being entered, so they register with it.
    always_comb begin
        ready_d  = 1'b0;
        ce_n_d   = 1'b1;
        oe_n_d   = 1'b1;
        we_n_d   = 1'b1;
        doe_d    = 1'b0;
        rvalid_d = 1'b0;
        wack_d   = 1'b0;
        case (state_d)
            S_IDLE:      ready_d = 1'b1;
            S_RD_WAIT:   begin ce_n_d = 1'b0; oe_n_d = 1'b0; end
            S_RD_LATCH:  begin ce_n_d = 1'b0; oe_n_d = 1'b0; rvalid_d = 1'b1; end
            S_WR_SETUP:  begin ce_n_d = 1'b0; doe_d = 1'b1; end
            S_WR_PULSE:  begin ce_n_d = 1'b0; doe_d = 1'b1; we_n_d = 1'b0; end
`ifdef SRAM_CTRL_WRVERIFY_EN
            S_WR_HOLD:   begin ce_n_d = 1'b0; doe_d = 1'b1; end
            S_VFY_WAIT:  begin ce_n_d = 1'b0; oe_n_d = 1'b0; end
            S_VFY_LATCH: begin ce_n_d = 1'b0; oe_n_d = 1'b0; wack_d = 1'b1; end
`else
            S_WR_HOLD:   begin ce_n_d = 1'b0; doe_d = 1'b1; wack_d = 1'b1; end
`endif
            default:     ;
        endcase
    end

    // Address/data hold for the whole access, read capture on entry to the latch cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sram_addr <= '0;
            sram_dout <= '0;
            rdata     <= '0;
        end else begin
            if (accept) begin
                sram_addr <= addr;
                sram_dout <= wdata;
            end
            if (state_d == S_RD_LATCH) rdata <= sram_din;
        end
    end

`ifdef SRAM_CTRL_WRVERIFY_EN
    // Sticky until reset: any read-back differing from the written byte.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            verify_err <= 1'b0;
        end else if (state_d == S_VFY_LATCH && sram_din != sram_dout) begin
            verify_err <= 1'b1;
        end
    end
`else
    assign verify_err = 1'b0;
`endif

endmodule

// File: tb/tb_sram_bus_ctrl.sv
// Scoreboard bench for sram_bus_ctrl: default-parameter DUT on an SRAM model plus a 1/1/0 fast instance.
module tb_sram_bus_ctrl;

`ifdef SRAM_CTRL_WRVERIFY_EN
    localparam bit VFY = 1'b1;
`else
    localparam bit VFY = 1'b0;
`endif
    localparam int RD_DONE   = 3;
    localparam int RD_RDY    = 5;
    localparam int WR_DONE   = VFY ? 7 : 4;
    localparam int WR_RDY    = VFY ? 9 : 5;
    localparam int F_RD_DONE = 2;
    localparam int F_RD_RDY  = 3;
    localparam int F_WR_DONE = VFY ? 5 : 3;
    localparam int F_WR_RDY  = VFY ? 6 : 4;

    typedef struct packed {
        logic        is_wr;
        logic [18:0] addr;
        logic [7:0]  data;
        int          done_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n, req, we;
    logic [18:0] addr;
    logic [7:0]  wdata, rdata, sram_dout, sram_din;
    logic ready, rvalid, wack, verify_err, sram_ce_n, sram_oe_n, sram_we_n, sram_doe;
    logic [18:0] sram_addr;

    logic f_reset_n, f_req, f_we;
    logic [18:0] f_addr, f_sram_addr;
    logic [7:0]  f_wdata, f_rdata, f_sram_dout, f_sram_din;
    logic f_ready, f_rvalid, f_wack, f_verify_err, f_ce_n, f_oe_n, f_we_n, f_doe;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int wack_cnt = 0;
    exp_t exp_q[$];
    exp_t fexp_q[$];
    int   rdy_q[$];
    int   frdy_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sram_bus_ctrl #(.AW(19), .WAIT_RD(2), .WAIT_WR(2), .TURN(1)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .ready(ready), .rdata(rdata), .rvalid(rvalid), .wack(wack), .verify_err(verify_err),
        .sram_addr(sram_addr), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
        .sram_we_n(sram_we_n), .sram_dout(sram_dout), .sram_din(sram_din), .sram_doe(sram_doe)
    );

    sram_bus_ctrl #(.AW(19), .WAIT_RD(1), .WAIT_WR(1), .TURN(0)) fdut (
        .clk(clk), .reset_n(f_reset_n), .req(f_req), .we(f_we), .addr(f_addr), .wdata(f_wdata),
        .ready(f_ready), .rdata(f_rdata), .rvalid(f_rvalid), .wack(f_wack), .verify_err(f_verify_err),
        .sram_addr(f_sram_addr), .sram_ce_n(f_ce_n), .sram_oe_n(f_oe_n),
        .sram_we_n(f_we_n), .sram_dout(f_sram_dout), .sram_din(f_sram_din), .sram_doe(f_doe)
    );

    // SRAM model for the main DUT, with an optional bit-3 stuck-at-0 fault.
    logic [7:0] mem [0:4095];
    bit stuck3 = 1'b0;
    always @(posedge clk)
        if (!sram_ce_n && !sram_we_n && sram_doe)
            mem[sram_addr[11:0]] <= stuck3 ? (sram_dout & 8'hF7) : sram_dout;
    assign sram_din = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr[11:0]] : 8'h00;

    // Fast instance sees a ROM whose contents are addr ^ 0x3C.
    assign f_sram_din = (!f_ce_n && !f_oe_n) ? (f_sram_addr[7:0] ^ 8'h3C) : 8'h00;

    task automatic check(input string name, input longint act, input longint req_v);
        vectors++;
        if (act !== req_v) begin
            miscompares++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req_v, cyc);
        end
    endtask

    // Main monitor: bus invariants, completions and ready returns.
    logic prev_ready = 1'b0, prev_doe = 1'b0, prev_we_n = 1'b1;
    int   last_oe_low = -100;
    int   we_first = 0, we_cnt = 0;
    exp_t em;
    always @(negedge clk) begin
        if (!sram_oe_n) check("oe_low_vs_doe", sram_doe, 1'b0);
        if (!sram_we_n) check("we_low_qualify", {sram_doe, sram_ce_n}, 2'b10);
        if (sram_doe && !prev_doe) check("turnaround_gap", (cyc - last_oe_low - 1) >= 1, 1'b1);
        if (!sram_we_n) begin
            if (prev_we_n) begin we_first = cyc; we_cnt = 1; end
            else we_cnt++;
        end
        if (wack) wack_cnt++;
        if (rvalid || wack) begin
            if (exp_q.size() == 0) check("unexpected_done", {rvalid, wack}, 2'b00);
            else begin
                em = exp_q.pop_front();
                check("done_kind", {rvalid, wack}, em.is_wr ? 2'b01 : 2'b10);
                check("done_cycle", cyc, em.done_cyc);
                check("addr_hold", sram_addr, em.addr);
                if (em.is_wr) begin
                    check("dout_hold", sram_dout, em.data);
                    check("we_first_cycle", we_first, em.done_cyc - WR_DONE + 2);
                    check("we_low_len", we_cnt, 2);
                end else check("rdata", rdata, em.data);
            end
        end
        if (ready && !prev_ready) begin
            if (rdy_q.size() == 0) check("unexpected_ready", ready, 1'b0);
            else check("ready_cycle", cyc, rdy_q.pop_front());
        end
        if (!sram_oe_n) last_oe_low = cyc;
        prev_ready = ready;
        prev_doe   = sram_doe;
        prev_we_n  = sram_we_n;
    end

    // Fast-instance monitor.
    logic f_prev_ready = 1'b0;
    exp_t fem;
    always @(negedge clk) begin
        if (!f_oe_n) check("f_oe_low_vs_doe", f_doe, 1'b0);
        if (!f_we_n) check("f_we_low_qualify", {f_doe, f_ce_n}, 2'b10);
        if (f_rvalid || f_wack) begin
            if (fexp_q.size() == 0) check("f_unexpected_done", {f_rvalid, f_wack}, 2'b00);
            else begin
                fem = fexp_q.pop_front();
                check("f_done_kind", {f_rvalid, f_wack}, fem.is_wr ? 2'b01 : 2'b10);
                check("f_done_cycle", cyc, fem.done_cyc);
                if (fem.is_wr) check("f_dout_hold", f_sram_dout, fem.data);
                else check("f_rdata", f_rdata, fem.data);
            end
        end
        if (f_ready && !f_prev_ready) begin
            if (frdy_q.size() == 0) check("f_unexpected_ready", f_ready, 1'b0);
            else check("f_ready_cycle", cyc, frdy_q.pop_front());
        end
        f_prev_ready = f_ready;
    end

    // Called at a negedge; d is write data, or the expected read data for reads.
    task automatic issue(input bit fast, input bit w, input logic [18:0] a, input logic [7:0] d,
                         input bit hold);
        int   n;
        exp_t e;
        n = 0;
        if (fast) begin f_req = 1'b1; f_we = w; f_addr = a; f_wdata = d; end
        else begin req = 1'b1; we = w; addr = a; wdata = d; end
        while (!(fast ? f_ready : ready)) begin
            @(negedge clk);
            n++;
            if (n > 60) begin
                check("accept_timeout", fast ? f_ready : ready, 1'b1);
                req = 1'b0; f_req = 1'b0;
                return;
            end
        end
        e.is_wr = w;
        e.addr  = a;
        e.data  = d;
        if (fast) begin
            e.done_cyc = cyc + (w ? F_WR_DONE : F_RD_DONE);
            fexp_q.push_back(e);
            frdy_q.push_back(cyc + (w ? F_WR_RDY : F_RD_RDY));
        end else begin
            e.done_cyc = cyc + (w ? WR_DONE : RD_DONE);
            exp_q.push_back(e);
            rdy_q.push_back(cyc + (w ? WR_RDY : RD_RDY));
        end
        @(negedge clk);
        if (!hold) begin
            if (fast) f_req = 1'b0; else req = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() + rdy_q.size() + fexp_q.size() + frdy_q.size()) != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check("drain_pending", exp_q.size() + rdy_q.size() + fexp_q.size() + frdy_q.size(), 0);
    endtask

    initial begin
        int n, base, wbefore;
        reset_n = 1'b0; f_reset_n = 1'b0;
        req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        f_req = 1'b0; f_we = 1'b0; f_addr = '0; f_wdata = '0;
        repeat (3) @(negedge clk);
        check("reset_strobes", {ready, sram_ce_n, sram_oe_n, sram_we_n, sram_doe, rvalid, wack}, 7'b0111000);
        check("reset_data", {sram_addr, sram_dout, rdata, verify_err}, 0);
        check("f_reset_strobes", {f_ready, f_ce_n, f_oe_n, f_we_n, f_doe}, 5'b01110);
        reset_n = 1'b1; f_reset_n = 1'b1;
        rdy_q.push_back(cyc + 1);
        frdy_q.push_back(cyc + 1);
        @(negedge clk);
        check("ready_after_reset", ready, 1'b1);
        repeat (3) begin
            @(negedge clk);
            check("idle_strobes", {sram_ce_n, sram_oe_n, sram_we_n, sram_doe}, 4'b1110);
        end

        issue(0, 1, 19'h01234, 8'hA5, 0); drain();
        issue(0, 0, 19'h01234, 8'hA5, 0); drain();
        issue(0, 1, 19'h00010, 8'h3C, 1);
        issue(0, 1, 19'h7FFFF, 8'hC3, 0); drain();
        check("rdata_held_over_writes", rdata, 8'hA5);
        issue(0, 0, 19'h00010, 8'h3C, 1);
        issue(0, 1, 19'h00020, 8'h5A, 1);
        issue(0, 0, 19'h00020, 8'h5A, 1);
        issue(0, 0, 19'h7FFFF, 8'hC3, 0); drain();
        issue(0, 1, 19'h00000, 8'hFF, 0);
        issue(0, 0, 19'h00000, 8'hFF, 0); drain();
        if (!VFY) check("verify_err_off", verify_err, 1'b0);

        // Reset pulse in the middle of a write strobe.
        req = 1'b1; we = 1'b1; addr = 19'h00100; wdata = 8'h77;
        n = 0;
        while (!ready && n < 60) begin @(negedge clk); n++; end
        base = cyc;
        @(negedge clk); req = 1'b0;
        @(negedge clk);
        check("pulse_cycle", cyc - base, 2);
        check("pulse_we_low", sram_we_n, 1'b0);
        wbefore = wack_cnt;
        #1 reset_n = 1'b0;
        #1 check("rst_strobes", {sram_ce_n, sram_oe_n, sram_we_n, sram_doe, ready}, 5'b11100);
        @(negedge clk);
        reset_n = 1'b1;
        rdy_q.push_back(cyc + 1);
        @(negedge clk);
        check("ready_after_rst_release", ready, 1'b1);
        repeat (6) @(negedge clk);
        check("no_wack_after_rst", wack_cnt - wbefore, 0);

`ifdef SRAM_CTRL_WRVERIFY_EN
        stuck3 = 1'b1;
        issue(0, 1, 19'h00200, 8'h08, 0); drain();
        check("verify_err_set", verify_err, 1'b1);
        issue(0, 1, 19'h00201, 8'h00, 0); drain();
        check("verify_err_sticky", verify_err, 1'b1);
        stuck3 = 1'b0;
`endif

        issue(1, 0, 19'h00011, 8'h2D, 1);
        issue(1, 0, 19'h000FF, 8'hC3, 1);
        issue(1, 0, 19'h00000, 8'h3C, 0); drain();
        issue(1, 1, 19'h00005, 8'h39, 0); drain();
        check("f_verify_err", f_verify_err, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
